// File: rtl/silent_pkg.sv
// Shared types and constants for the silent-mode step sequencer.
package silent_pkg;

    localparam int unsigned DATA_W = 8;

    typedef logic [DATA_W-1:0] duty_t;
    typedef logic [DATA_W-1:0] phase_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SWEEP   = 2'd1,
        PUBLISH = 2'd2
    } state_t;

    // A phase difference of exactly half a turn steps downward.
    localparam bit TIE_DOWN = 1'b1;

endpackage

// File: rtl/silent_step_unit.sv
// One-channel duty/phase slew stepper, purely combinational.
// SILENT_PHASE_WRAP_EN selects circular shortest-path phase stepping;
// otherwise phase uses the same linear saturating rule as duty.
module silent_step_unit
    import silent_pkg::*;
(
    input  duty_t        cur_duty,
    input  phase_t       cur_phase,
    input  duty_t        tgt_duty,
    input  phase_t       tgt_phase,
    input  logic [7:0]   step,
    input  logic         en,
    output duty_t        next_duty,
    output phase_t       next_phase
);

    // Linear move toward target by at most st; lands on target when close.
    function automatic logic [7:0] lin_step(input logic [7:0] cur,
                                            input logic [7:0] tgt,
                                            input logic [7:0] st,
                                            input logic       en_i);
        logic [8:0] diff;
        logic [8:0] mag;
        logic [7:0] res;
        diff = {1'b0, tgt} - {1'b0, cur};
        mag  = diff[8] ? (9'd0 - diff) : diff;
        if (!en_i || (mag <= {1'b0, st})) begin
            res = tgt;
        end else if (diff[8]) begin
            res = cur - st;
        end else begin
            res = cur + st;
        end
        return res;
    endfunction

`ifdef SILENT_PHASE_WRAP_EN
    // Circular move along the shorter arc, result modulo 256.
    function automatic logic [7:0] wrap_step(input logic [7:0] cur,
                                             input logic [7:0] tgt,
                                             input logic [7:0] st,
                                             input logic       en_i);
        logic [7:0] d;
        logic [8:0] down_dist;
        logic [7:0] amt;
        logic       up;
        logic [7:0] res;
        d         = tgt - cur;
        down_dist = 9'd256 - {1'b0, d};
        up        = (d[7] == 1'b0) || ((d == 8'd128) && !TIE_DOWN);
        amt       = 8'd0;
        if (!en_i) begin
            res = tgt;
        end else if (d == 8'd0) begin
            res = cur;
        end else if (up) begin
            amt = (st < d) ? st : d;
            res = cur + amt;
        end else begin
            amt = ({1'b0, st} < down_dist) ? st : down_dist[7:0];
            res = cur - amt;
        end
        return res;
    endfunction
`endif

    // Next duty/phase for the channel currently being swept.
    always_comb begin
        next_duty  = cur_duty;
        next_phase = cur_phase;
        next_duty  = lin_step(cur_duty, tgt_duty, step, en);
`ifdef SILENT_PHASE_WRAP_EN
        next_phase = wrap_step(cur_phase, tgt_phase, step, en);
`else
        next_phase = lin_step(cur_phase, tgt_phase, step, en);
`endif
    end

endmodule

// File: rtl/silent_step_sequencer.sv
// Time-multiplexed duty/phase slew limiter: on UPDATE it sweeps every
// channel through one shared stepper, then publishes all results at once.
// Optional macro SILENT_PHASE_WRAP_EN enables circular phase stepping.
module silent_step_sequencer
    import silent_pkg::*;
#(
    parameter int unsigned TRANS_NUM = 249,
    parameter int unsigned IDX_W     = 8
)
(
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      UPDATE,
    input  logic                      ENABLE,
    input  logic [7:0]                STEP,
    input  duty_t  [0:TRANS_NUM-1]    DUTY,
    input  phase_t [0:TRANS_NUM-1]    PHASE,
    output duty_t  [0:TRANS_NUM-1]    DUTYS,
    output phase_t [0:TRANS_NUM-1]    PHASES,
    output logic                      BUSY,
    output logic                      OVERRUN
);

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [7:0]              step_q;
    logic                    en_q;
    duty_t  [0:TRANS_NUM-1]  cur_duty;
    phase_t [0:TRANS_NUM-1]  cur_phase;
    duty_t                   next_duty;
    phase_t                  next_phase;
    logic                    last_ch;

    assign last_ch = (idx == IDX_W'(TRANS_NUM - 1));

    // Shared stepper, fed with the channel selected by idx.
    silent_step_unit u_step (
        .cur_duty   (cur_duty[idx]),
        .cur_phase  (cur_phase[idx]),
        .tgt_duty   (DUTY[idx]),
        .tgt_phase  (PHASE[idx]),
        .step       (step_q),
        .en         (en_q),
        .next_duty  (next_duty),
        .next_phase (next_phase)
    );

    // Sweep control, busy flag and sticky overrun detection.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            idx     <= '0;
            step_q  <= '0;
            en_q    <= 1'b0;
            BUSY    <= 1'b0;
            OVERRUN <= 1'b0;
        end else begin
            if (UPDATE && (state != IDLE)) begin
                OVERRUN <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (UPDATE) begin
                        step_q <= STEP;
                        en_q   <= ENABLE;
                        idx    <= '0;
                        state  <= SWEEP;
                        BUSY   <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (last_ch) begin
                        idx   <= '0;
                        state <= PUBLISH;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                PUBLISH: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

    // Per-channel current values, updated one channel per sweep cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cur_duty  <= '0;
            cur_phase <= '0;
        end else if (state == SWEEP) begin
            cur_duty[idx]  <= next_duty;
            cur_phase[idx] <= next_phase;
        end
    end

    // Atomic publish of the whole current arrays to the delay stage.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            DUTYS  <= '0;
            PHASES <= '0;
        end else if (state == PUBLISH) begin
            DUTYS  <= cur_duty;
            PHASES <= cur_phase;
        end
    end

endmodule

// File: tb/tb_silent_step_sequencer.sv
// Self-checking bench for silent_step_sequencer: table vectors plus
// hand-written reset/overrun sequences, checked through a publish scoreboard.
module tb_silent_step_sequencer;

    localparam int N = 249;
`ifdef SILENT_PHASE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              UPDATE = 1'b0;
    logic              ENABLE = 1'b0;
    logic [7:0]        STEP = 8'd0;
    logic [0:N-1][7:0] DUTY;
    logic [0:N-1][7:0] PHASE;
    logic [0:N-1][7:0] DUTYS;
    logic [0:N-1][7:0] PHASES;
    logic              BUSY;
    logic              OVERRUN;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [0:N-1][7:0] d;
        logic [0:N-1][7:0] p;
        int                t;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        bit en;
        int step;
        int dt;
        int pt;
        int ed;
        int ep;
    } vec_t;
    vec_t vecs[20];

    int md[N];
    int mp[N];

    silent_step_sequencer #(.TRANS_NUM(N), .IDX_W(8)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .UPDATE  (UPDATE),
        .ENABLE  (ENABLE),
        .STEP    (STEP),
        .DUTY    (DUTY),
        .PHASE   (PHASE),
        .DUTYS   (DUTYS),
        .PHASES  (PHASES),
        .BUSY    (BUSY),
        .OVERRUN (OVERRUN)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int model_duty(int cur, int tgt, int st, bit en);
        int d;
        if (!en) return tgt;
        d = tgt - cur;
        if (d >= -st && d <= st) return tgt;
        return (d > 0) ? cur + st : cur - st;
    endfunction

    function automatic int model_phase(int cur, int tgt, int st, bit en);
        int d;
        int amt;
        if (!en) return tgt;
        if (!WRAP) return model_duty(cur, tgt, st, en);
        d = (tgt - cur + 256) % 256;
        if (d == 0) return cur;
        if (d < 128) begin
            amt = (st < d) ? st : d;
            return (cur + amt) % 256;
        end
        amt = (st < 256 - d) ? st : 256 - d;
        return (cur - amt + 256) % 256;
    endfunction

    task automatic set_uniform(input int d, input int p);
        for (int i = 0; i < N; i++) begin
            DUTY[i]  = 8'(d);
            PHASE[i] = 8'(p);
        end
    endtask

    task automatic set_random();
        for (int i = 0; i < N; i++) begin
            DUTY[i]  = 8'($urandom_range(0, 255));
            PHASE[i] = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            md[i] = 0;
            mp[i] = 0;
        end
    endtask

    // Pulse UPDATE; when accepted, queue the expected published arrays.
    task automatic do_update(input bit accept, input bit use_tbl, input int ed, input int ep);
        exp_t e;
        if (accept) begin
            for (int i = 0; i < N; i++) begin
                if (use_tbl) begin
                    md[i] = ed;
                    mp[i] = ep;
                end else begin
                    md[i] = model_duty(md[i], int'(DUTY[i]), int'(STEP), ENABLE);
                    mp[i] = model_phase(mp[i], int'(PHASE[i]), int'(STEP), ENABLE);
                end
                e.d[i] = 8'(md[i]);
                e.p[i] = 8'(mp[i]);
            end
        end
        UPDATE = 1'b1;
        tick();
        UPDATE = 1'b0;
        if (accept) begin
            e.t = cyc;
            sbq.push_back(e);
            chk("busy_rise", int'(BUSY), 1);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((BUSY || sbq.size() != 0) && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) begin
            errors++;
            checks++;
            $display("FAIL idle_timeout: busy=%0d pending=%0d after %0d cycles", BUSY, sbq.size(), n);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        int nz;
        nz = 0;
        for (int i = 0; i < N; i++) begin
            if (DUTYS[i] != 8'd0 || PHASES[i] != 8'd0) nz++;
        end
        chk(nm, nz, 0);
    endtask

    // Publish monitor: compares outputs and latency when BUSY falls.
    logic prev_busy = 1'b0;
    always @(negedge CLK) begin : mon
        exp_t e;
        int   bad;
        if (!RST_N) begin
            prev_busy = 1'b0;
        end else begin
            if (prev_busy && !BUSY) begin
                if (sbq.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_publish at cycle %0d: got publish expected none", cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("latency", cyc - e.t, N + 1);
                    bad = -1;
                    for (int ch = 0; ch < N; ch++) begin
                        if (bad < 0 && (DUTYS[ch] !== e.d[ch] || PHASES[ch] !== e.p[ch])) bad = ch;
                    end
                    checks++;
                    if (bad >= 0) begin
                        errors++;
                        $display("FAIL publish_data ch=%0d: got duty=%0d phase=%0d expected duty=%0d phase=%0d",
                                 bad, DUTYS[bad], PHASES[bad], e.d[bad], e.p[bad]);
                    end
                end
            end
            prev_busy = BUSY;
        end
    end

    initial begin
        vecs[0]  = '{1'b0,   0, 200,  50, 200,  50};
        vecs[1]  = '{1'b0,   0,   0,   0,   0,   0};
        vecs[2]  = '{1'b1,  16, 100,   0,  16,   0};
        vecs[3]  = '{1'b1,  16, 100,   0,  32,   0};
        vecs[4]  = '{1'b1,  16, 100,   0,  48,   0};
        vecs[5]  = '{1'b1,  16, 100,   0,  64,   0};
        vecs[6]  = '{1'b1,  16, 100,   0,  80,   0};
        vecs[7]  = '{1'b1,  16, 100,   0,  96,   0};
        vecs[8]  = '{1'b1,  16, 100,   0, 100,   0};
        vecs[9]  = '{1'b1,  16, 100,   0, 100,   0};
        vecs[10] = '{1'b0,   0, 100, 250, 100, 250};
        vecs[11] = '{1'b1,  10, 100,   5, 100, WRAP ?   4 : 240};
        vecs[12] = '{1'b1,  10, 100,   5, 100, WRAP ?   5 : 230};
        vecs[13] = '{1'b0,   0, 100,   0, 100,   0};
        vecs[14] = '{1'b1, 200, 100, 128, 100, 128};
        vecs[15] = '{1'b0,   0, 100,   0, 100,   0};
        vecs[16] = '{1'b1,   4, 100, 128, 100, WRAP ? 252 :   4};
        vecs[17] = '{1'b1,   0,   7,   9, 100, WRAP ? 252 :   4};
        vecs[18] = '{1'b1,  30,  50,   9,  70,   9};
        vecs[19] = '{1'b1,  30,   0, 200,  40, WRAP ? 235 :  39};

        set_uniform(0, 0);
        model_reset();

        // Reset state
        tick();
        tick();
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_overrun", int'(OVERRUN), 0);
        chk_all_zero("rst_outputs");
        RST_N = 1'b1;
        tick();

        // Table-driven uniform-target vectors
        for (int v = 0; v < 20; v++) begin
            ENABLE = vecs[v].en;
            STEP   = 8'(vecs[v].step);
            set_uniform(vecs[v].dt, vecs[v].pt);
            do_update(1'b1, 1'b1, vecs[v].ed, vecs[v].ep);
            wait_idle();
        end

        // Random per-channel targets against the model
        for (int k = 0; k < 4; k++) begin
            ENABLE = 1'b1;
            STEP   = (k == 3) ? 8'd0 : 8'($urandom_range(1, 60));
            set_random();
            do_update(1'b1, 1'b0, 0, 0);
            wait_idle();
        end

        // Phase 250 -> 5 with step 10 over 25 updates
        ENABLE = 1'b0;
        STEP   = 8'd0;
        set_uniform(100, 250);
        do_update(1'b1, 1'b0, 0, 0);
        wait_idle();
        ENABLE = 1'b1;
        STEP   = 8'd10;
        set_uniform(100, 5);
        for (int k = 0; k < 25; k++) begin
            do_update(1'b1, 1'b0, 0, 0);
            wait_idle();
        end
        chk("phase_after_25", int'(PHASES[0]), 5);

        // Reset in the middle of a sweep
        ENABLE = 1'b0;
        set_uniform(200, 50);
        do_update(1'b1, 1'b0, 0, 0);
        repeat (119) tick();
        RST_N = 1'b0;
        #1;
        sbq.delete();
        model_reset();
        chk("midrst_busy", int'(BUSY), 0);
        chk_all_zero("midrst_outputs");
        repeat (3) tick();
        RST_N = 1'b1;
        chk("midrst_overrun", int'(OVERRUN), 0);
        repeat (300) tick();
        chk_all_zero("midrst_no_publish");
        ENABLE = 1'b1;
        STEP   = 8'd20;
        set_random();
        do_update(1'b1, 1'b0, 0, 0);
        wait_idle();

        // UPDATE on the PUBLISH->IDLE edge is ignored and flagged
        STEP = 8'd5;
        set_random();
        do_update(1'b1, 1'b0, 0, 0);
        repeat (N) tick();
        UPDATE = 1'b1;
        tick();
        UPDATE = 1'b0;
        chk("pub_edge_overrun", int'(OVERRUN), 1);
        chk("pub_edge_busy", int'(BUSY), 0);
        tick();
        chk("pub_edge_no_restart", int'(BUSY), 0);
        wait_idle();

        // Reset, then UPDATE 100 cycles into a sweep
        RST_N = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
        model_reset();
        chk("rst2_overrun", int'(OVERRUN), 0);
        STEP = 8'd16;
        set_random();
        do_update(1'b1, 1'b0, 0, 0);
        repeat (99) tick();
        UPDATE = 1'b1;
        tick();
        UPDATE = 1'b0;
        chk("midsweep_overrun", int'(OVERRUN), 1);
        wait_idle();
        repeat (300) tick();
        chk("overrun_sticky", int'(OVERRUN), 1);
        chk("overrun_idle", int'(BUSY), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
